// File: rtl/cpu_run_sequencer_if.sv
// Handshake bundle between the CPU run sequencer and its board/CPU neighbours.
// CYCLE_LIMIT_EN adds the cycle_limit input and the limit_hit flag.
interface cpu_run_sequencer_if;
   logic        run_sw;
   logic        step_btn;
   logic        halt_req;
   logic        cpu_ce;
   logic        cpu_rst;
   logic [1:0]  mode;
   logic [15:0] cycle_cnt;
   logic [2:0]  led_rgb;
`ifdef CYCLE_LIMIT_EN
   logic [15:0] cycle_limit;
   logic        limit_hit;
`endif

   modport master (
      output run_sw, step_btn, halt_req,
`ifdef CYCLE_LIMIT_EN
      output cycle_limit,
      input  limit_hit,
`endif
      input  cpu_ce, cpu_rst, mode, cycle_cnt, led_rgb
   );

   modport slave (
      input  run_sw, step_btn, halt_req,
`ifdef CYCLE_LIMIT_EN
      input  cycle_limit,
      output limit_hit,
`endif
      output cpu_ce, cpu_rst, mode, cycle_cnt, led_rgb
   );
endinterface

// File: rtl/cpu_run_sequencer.sv
// Run/halt/step sequencer issuing a single-cycle CPU clock enable in the clk_src domain.
// Optional CYCLE_LIMIT_EN: halt RUN once cycle_cnt reaches cycle_limit and flag limit_hit.
//
// state      | meaning
// RST_HOLD   | CPU held in reset for RST_CYCLES after reset releases
// HALT       | CPU stopped, waiting for a fresh run or step edge
// RUN        | one cpu_ce every 2^DIV_LOG2 cycles until halt_req or run switch low
// STEP       | one cpu_ce, then back to HALT
module cpu_run_sequencer #(
   parameter int DIV_LOG2   = 25,
   parameter int DEB_CYCLES = 480000,
   parameter int RST_CYCLES = 16
) (
   input  logic clk_src,
   input  logic reset,
   cpu_run_sequencer_if.slave bus
);

   localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

   typedef enum logic [1:0] {
      S_RST_HOLD = 2'b00,
      S_HALT     = 2'b01,
      S_RUN      = 2'b10,
      S_STEP     = 2'b11
   } state_t;

   // bit 0 = run switch, bit 1 = step button
   logic [1:0]       raw_in;
   logic [1:0]       sync1_q, sync2_q, deb_q, deb_prev_q;
   logic [DEB_W-1:0] deb_cnt_q [2];
   logic             run_deb, run_rise, step_rise;

   state_t              state_q, state_d;
   logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
   logic [DIV_LOG2-1:0] div_q, div_d;
   logic                tick;
   logic                ce_q, ce_d;
   logic                rst_q, rst_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [2:0]          led_q, led_d;

   assign raw_in    = {bus.step_btn, bus.run_sw};
   assign run_deb   = deb_q[0];
   assign run_rise  = deb_q[0] & ~deb_prev_q[0];
   assign step_rise = deb_q[1] & ~deb_prev_q[1];
   assign tick      = &div_q;

   // Counter tracks consecutive cycles where the synchronized input disagrees with the debounced one.
   always_ff @(posedge clk_src) begin
      if (reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
      end else begin
         sync1_q    <= raw_in;
         sync2_q    <= sync1_q;
         deb_prev_q <= deb_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
               deb_cnt_q[i] <= '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
               deb_q[i]     <= sync2_q[i];
               deb_cnt_q[i] <= '0;
            end else begin
               deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
            end
         end
      end
   end

`ifdef CYCLE_LIMIT_EN
   logic limit_hit_q, limit_hit_d;
   logic limit_reached;
   assign limit_reached = ce_q && (bus.cycle_limit != 16'd0) && ((cnt_q + 16'd1) == bus.cycle_limit);
   assign bus.limit_hit = limit_hit_q;
`endif

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      div_d     = '0;
      ce_d      = 1'b0;
      rst_d     = 1'b0;
      cnt_d     = ce_q ? cnt_q + 16'd1 : cnt_q;
      led_d     = 3'b100;
`ifdef CYCLE_LIMIT_EN
      limit_hit_d = (run_rise | step_rise) ? 1'b0 : limit_hit_q;
`endif
      case (state_q)
         S_RST_HOLD: begin
            rst_d = 1'b1;
            cnt_d = '0;
            if (rst_cnt_q == '0) state_d = S_HALT;
            else                 rst_cnt_d = rst_cnt_q - 1'b1;
         end
         S_HALT: begin
            if (run_rise && !bus.halt_req)       state_d = S_RUN;
            else if (step_rise && !bus.halt_req) state_d = S_STEP;
         end
         S_RUN: begin
            div_d = div_q + 1'b1;
            ce_d  = tick & ~bus.halt_req;
            if (bus.halt_req || !run_deb) begin
               state_d = S_HALT;
            end
`ifdef CYCLE_LIMIT_EN
            else if (limit_reached) begin
               state_d     = S_HALT;
               limit_hit_d = 1'b1;
            end
`endif
         end
         S_STEP: begin
            ce_d    = 1'b1;
            state_d = S_HALT;
         end
      endcase
      case (state_q)
         S_RST_HOLD: led_d = 3'b100;
         S_HALT:     led_d = 3'b001;
         S_RUN:      led_d = 3'b010;
         S_STEP:     led_d = 3'b011;
      endcase
   end

   always_ff @(posedge clk_src) begin
      if (reset) begin
         state_q   <= S_RST_HOLD;
         rst_cnt_q <= RST_LAST;
         div_q     <= '0;
         ce_q      <= 1'b0;
         rst_q     <= 1'b1;
         cnt_q     <= '0;
         led_q     <= 3'b100;
`ifdef CYCLE_LIMIT_EN
         limit_hit_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         div_q     <= div_d;
         ce_q      <= ce_d;
         rst_q     <= rst_d;
         cnt_q     <= cnt_d;
         led_q     <= led_d;
`ifdef CYCLE_LIMIT_EN
         limit_hit_q <= limit_hit_d;
`endif
      end
   end

   assign bus.cpu_ce    = ce_q;
   assign bus.cpu_rst   = rst_q;
   assign bus.mode      = state_q;
   assign bus.cycle_cnt = cnt_q;
   assign bus.led_rgb   = led_q;

endmodule
